// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcode
// constants, immediate-format enum, decoded bundle struct and the helper
// functions used by the decoder and the register file.
package id_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } imm_fmt_e;

  // Non-datapath part of the decoded bundle held in the output register
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } id_bundle_t;

  // Immediate format selected by the major opcode
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: return FMT_I;
      OP_STORE:                            return FMT_S;
      OP_BRANCH:                           return FMT_B;
      OP_LUI, OP_AUIPC:                    return FMT_U;
      OP_JAL:                              return FMT_J;
      OP_REG, OP_REG32:                    return FMT_R;
      default:                             return FMT_BAD;
    endcase
  endfunction

  // 32-bit sign-extended immediate; the caller widens to XLEN
  function automatic logic [31:0] imm32(input logic [31:0] ins, input imm_fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{ins[31]}}, ins[31:20]};
      FMT_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   return {ins[31:12], 12'b0};
      FMT_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  // Register fields that actually name a register for each format; the
  // other bit positions carry immediate bits and are not range-checked.
  function automatic logic uses_rs1(input imm_fmt_e fmt);
    return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  endfunction

  function automatic logic uses_rs2(input imm_fmt_e fmt);
    return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  endfunction

  function automatic logic uses_rd(input imm_fmt_e fmt);
    return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  endfunction

  // Register index lies inside the implemented register count
  function automatic logic reg_ok(input logic [4:0] idx, input int unsigned nreg);
    return 6'(idx) < 6'(nreg);
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Architectural register file: NREG x XLEN, two combinational read ports,
// one write port. x0 and out-of-range indices read 0 and ignore writes.
//   clk, rst_n          clock, async active-low reset (clears all entries)
//   i_we/i_wa/i_wd      write enable / address / data
//   i_ra1, i_ra2        read addresses
//   o_rd1_c, o_rd2_c    combinational read data
module regfile
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1_c,
  output logic [XLEN-1:0] o_rd2_c
);

  localparam int unsigned RW = $clog2(NREG);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_we;

  assign w_we = i_we && (i_wa != 5'd0) && reg_ok(i_wa, NREG);

  // Storage; entry 0 is never written so it stays at its reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[i_wa[RW-1:0]] <= i_wd;
    end
  end

  // Read ports
  assign o_rd1_c = ((i_ra1 == 5'd0) || !reg_ok(i_ra1, NREG)) ? '0 : r_regs[i_ra1[RW-1:0]];
  assign o_rd2_c = ((i_ra2 == 5'd0) || !reg_ok(i_ra2, NREG)) ? '0 : r_regs[i_ra2[RW-1:0]];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the fetched word, reads operands from
// the register file (with write-back bypass) and holds the result in a
// single output register handshaked with execute.
//   clk, rst_n                      clock, async active-low reset
//   if_valid/if_ready/if_instr/if_pc  fetch side handshake and payload
//   flush                           drop held and incoming instruction
//   wb_en/wb_rd/wb_data             register write-back port
//   ex_valid/ex_ready               execute side handshake
//   ex_pc/ex_imm/ex_rs1_val/ex_rs2_val, ex_opcode/ex_f3/ex_f7/ex_rd,
//   ex_illegal                      decoded bundle
module id_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_f3,
  output logic [6:0]      ex_f7,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal
);

  id_bundle_t      w_dec;
  imm_fmt_e        w_fmt;
  logic            w_bad_idx;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_rf, w_rs2_rf;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;
  logic            w_load, w_wb_hit, w_hold;

  logic            r_valid;
  id_bundle_t      r_bun;
  logic [XLEN-1:0] r_pc, r_imm, r_rs1_val, r_rs2_val;

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (wb_en),
    .i_wa    (wb_rd),
    .i_wd    (wb_data),
    .i_ra1   (w_dec.rs1),
    .i_ra2   (w_dec.rs2),
    .o_rd1_c (w_rs1_rf),
    .o_rd2_c (w_rs2_rf)
  );

  // Handshake: the output register can take a new bundle when empty or draining
  assign if_ready = !r_valid || ex_ready;
  assign w_load   = if_valid && if_ready && !flush;
  assign w_hold   = r_valid && !ex_ready;
  // Same qualification as the register-file write so bypass matches storage
  assign w_wb_hit = wb_en && (wb_rd != 5'd0) && reg_ok(wb_rd, NREG);

  // Field extraction, legality and immediate generation
  always_comb begin
    w_dec        = '0;
    w_fmt        = imm_fmt(if_instr[6:0]);
    w_imm        = '0;
    w_dec.opcode = if_instr[6:0];
    w_dec.rd     = if_instr[11:7];
    w_dec.f3     = if_instr[14:12];
    w_dec.rs1    = if_instr[19:15];
    w_dec.rs2    = if_instr[24:20];
    w_dec.f7     = if_instr[31:25];
    w_bad_idx    = (uses_rs1(w_fmt) && !reg_ok(w_dec.rs1, NREG)) ||
                   (uses_rs2(w_fmt) && !reg_ok(w_dec.rs2, NREG)) ||
                   (uses_rd(w_fmt)  && !reg_ok(w_dec.rd,  NREG));
    w_dec.illegal = (w_fmt == FMT_BAD) || w_bad_idx;
    if (!w_dec.illegal) w_imm = XLEN'($signed(imm32(if_instr, w_fmt)));
  end

  // Write-through: a write landing this edge supersedes the stale array value
  assign w_rs1_val = (w_wb_hit && (wb_rd == w_dec.rs1)) ? wb_data : w_rs1_rf;
  assign w_rs2_val = (w_wb_hit && (wb_rd == w_dec.rs2)) ? wb_data : w_rs2_rf;

  // Output register with flush priority and operand refresh while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_bun     <= '0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
    end else begin
      if (flush)         r_valid <= 1'b0;
      else if (w_load)   r_valid <= 1'b1;
      else if (ex_ready) r_valid <= 1'b0;

      if (w_load) begin
        r_bun     <= w_dec;
        r_pc      <= if_pc;
        r_imm     <= w_imm;
        r_rs1_val <= w_rs1_val;
        r_rs2_val <= w_rs2_val;
      end else if (w_hold) begin
        if (w_wb_hit && (wb_rd == r_bun.rs1)) r_rs1_val <= wb_data;
        if (w_wb_hit && (wb_rd == r_bun.rs2)) r_rs2_val <= wb_data;
      end
    end
  end

  assign ex_valid   = r_valid;
  assign ex_pc      = r_pc;
  assign ex_imm     = r_imm;
  assign ex_rs1_val = r_rs1_val;
  assign ex_rs2_val = r_rs2_val;
  assign ex_opcode  = r_bun.opcode;
  assign ex_f3      = r_bun.f3;
  assign ex_f7      = r_bun.f7;
  assign ex_rd      = r_bun.rd;
  assign ex_illegal = r_bun.illegal;

endmodule
